uc_datapath: RTL and testbench
==============================

# uc_datapath

Processing-unit counterpart of the accumulator CPU's control unit. It receives the control unit's command strobes (`sel_UAL`, `load_*`, `clear_carry`, `enable_mem`, `w_mem`, `adr`) and returns memory read data and the carry flag. It holds the R1, accumulator and carry registers, the 8-bit UAL and the program/data RAM. A boot-load port fills the RAM from a byte stream while `boot` is high.

## Interface
- `ADDR_W`, default 6: RAM address width; depth is 2^ADDR_W.
- `DATA_W`, default 8: data width of R1, the accumulator, the UAL and the RAM.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `ce` in 1: clock enable. When 0, all state is frozen, including RAM writes and the boot FSM.
- `sel_UAL` in 3: UAL operation select.
- `load_R1` in 1: R1 <= `data_out`.
- `load_accu` in 1: accumulator <= UAL result.
- `load_carry` in 1: carry <= UAL carry-out.
- `clear_carry` in 1: carry <= 0. Has priority over `load_carry`.
- `enable_mem` in 1: RAM access strobe.
- `w_mem` in 1: with `enable_mem`, selects write (1) or read (0).
- `adr` in ADDR_W: RAM address.
- `data_out` out DATA_W: registered RAM read data, connected to the control unit's `data_in`.
- `carry` out 1: carry register.
- `accu` out DATA_W: accumulator value, used as debug and write data.
- `boot` in 1: boot-load request.
- `boot_data` in DATA_W: boot byte.
- `boot_valid` in 1: `boot_data` is valid this cycle.
- `boot_done` out 1: the full RAM has been loaded.

## Operation
- **Reset values** (reset takes effect only when `rst`=1 at a clock edge, regardless of `ce`): R1, accu, carry, `data_out` = 0; boot FSM = IDLE; boot pointer = 0; `boot_done` = 0. RAM contents are not reset.
- **UAL** (combinational, operands A = accu, B = R1):
  - 000: ADD, A+B, carry-out = bit DATA_W of the sum.
  - 001: SUB, A−B, carry-out = 1 when A ≥ B (not-borrow).
  - 010: AND; 011: OR; 100: XOR; 101: NOR.
  - 110: pass B; 111: pass A.
  - Logic and pass ops produce carry-out 0.
  - Results are truncated to DATA_W with wrap-around.
- **Registers**:
  - `load_accu` and `load_carry` may assert in the same cycle and both use the same UAL evaluation.
  - `load_R1` together with `load_accu`: the UAL uses the old R1.
- **RAM, normal mode** (boot FSM in IDLE):
  - `enable_mem`=1, `w_mem`=0: `data_out` <= mem[adr] at the next edge.
  - `enable_mem`=1, `w_mem`=1: mem[adr] <= accu (the pre-edge value); `data_out` holds its value.
  - `enable_mem`=0: `data_out` holds its value.
- **Boot FSM**:
  - IDLE, `boot`=1: go to LOAD, pointer <= 0.
  - LOAD, `boot_valid`=1: mem[ptr] <= `boot_data`, ptr++. The write to address 2^ADDR_W−1 moves the FSM to DONE and wraps ptr to 0.
  - LOAD, `boot`=0: abort to IDLE. Already-written bytes stay in RAM.
  - DONE: `boot_done`=1 and `boot_valid` is ignored. `boot`=0 moves the FSM to IDLE.
  - In LOAD and DONE, control-side `enable_mem` and `w_mem` are ignored and `data_out` holds. The register `load_*` strobes still act.
  - If `boot` and `boot_valid` are both 1 in IDLE, that byte is not written; the first write happens in LOAD.

## Timing
- RAM read latency is 1 cycle: address at edge N, `data_out` valid after edge N. `load_R1` may use it at edge N+1.
- Register loads and the carry take effect at the edge where the strobe is sampled.
- A boot write takes 1 cycle per valid byte. Minimum full load = 1 + 2^ADDR_W cycles from `boot` rising to `boot_done`.
- `boot_done` is registered. It rises the cycle after the last byte's edge and falls the cycle after `boot` is sampled low.
- `ce`=0 inserts stall cycles that change nothing. A valid byte presented during a stall is not captured.
- `rst` during LOAD forces IDLE next cycle; the partial RAM contents remain.

## Structure
- Package `uc_pkg`:
  - UAL opcode localparams: `UAL_ADD`, `UAL_SUB`, `UAL_AND`, `UAL_OR`, `UAL_XOR`, `UAL_NOR`, `UAL_PASS_B`, `UAL_PASS_A`.
  - Boot state encoding: IDLE, LOAD, DONE.
  - Default widths.
- Sub-module `uc_ual`: the combinational UAL (A, B, sel → result, carry_out). The registers, RAM array and boot FSM live in `uc_datapath`.

## Test plan
- **Reset:** drive `rst`=1 for 2 cycles with `ce`=1 → `accu`=0x00, `carry`=0, `data_out`=0x00, `boot_done`=0.
- **Boot load** (ADDR_W=6): `boot`=1, then 64 valid bytes 0x00..0x3F → `boot_done`=1 exactly 1 cycle after the last write. Reading `adr`=0x2A then gives `data_out`=0x2A after 1 edge.
- **ADD with carry:** load R1=0xF0 (memory read followed by `load_R1`) with accu=0x20, then `sel_UAL`=000 with `load_accu`+`load_carry` → `accu`=0x10, `carry`=1.
- **SUB and clear priority:**
  - accu=0x05, R1=0x07, SUB with `load_carry` → `accu`=0xFE, `carry`=0.
  - Then `clear_carry`+`load_carry` with accu=R1 SUB → `carry`=0.
- **Write then read:** accu=0x5A, write `adr`=3, then read `adr`=3 → `data_out`=0x5A 1 cycle later. During the write cycle, `data_out` keeps its previous value.
- **Boot abort and stall:**
  - Drop `boot` after 10 bytes → FSM in IDLE, `boot_done`=0, bytes 0..9 intact.
  - Re-boot with `ce`=0 on alternate cycles → only bytes presented while `ce`=1 are written, in order from address 0.

Source files
------------

// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - shared widths, UAL opcodes and boot state encoding for the datapath
package uc_pkg;

    localparam int UC_ADDR_W = 6;
    localparam int UC_DATA_W = 8;
    localparam int UAL_SEL_W = 3;

    localparam logic [UAL_SEL_W-1:0] UAL_ADD    = 3'b000;
    localparam logic [UAL_SEL_W-1:0] UAL_SUB    = 3'b001;
    localparam logic [UAL_SEL_W-1:0] UAL_AND    = 3'b010;
    localparam logic [UAL_SEL_W-1:0] UAL_OR     = 3'b011;
    localparam logic [UAL_SEL_W-1:0] UAL_XOR    = 3'b100;
    localparam logic [UAL_SEL_W-1:0] UAL_NOR    = 3'b101;
    localparam logic [UAL_SEL_W-1:0] UAL_PASS_B = 3'b110;
    localparam logic [UAL_SEL_W-1:0] UAL_PASS_A = 3'b111;

    typedef enum logic [1:0] {
        BOOT_IDLE = 2'd0,
        BOOT_LOAD = 2'd1,
        BOOT_DONE = 2'd2
    } boot_state_t;

endpackage

// File: rtl/uc_ual.sv
// rtl/uc_ual.sv - combinational arithmetic/logic unit, A = accumulator, B = R1
module uc_ual
    import uc_pkg::*;
#(
    parameter int DATA_W = UC_DATA_W
) (
    input  logic [DATA_W-1:0]    a,
    input  logic [DATA_W-1:0]    b,
    input  logic [UAL_SEL_W-1:0] sel,
    output logic [DATA_W-1:0]    result,
    output logic                 carry_out
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result    = a;
        carry_out = 1'b0;
        case (sel)
            UAL_ADD: begin
                result    = sum[DATA_W-1:0];
                carry_out = sum[DATA_W];
            end
            UAL_SUB: begin
                // The extra difference bit is the borrow; carry reports not-borrow (A >= B).
                result    = diff[DATA_W-1:0];
                carry_out = ~diff[DATA_W];
            end
            UAL_AND:    result = a & b;
            UAL_OR:     result = a | b;
            UAL_XOR:    result = a ^ b;
            UAL_NOR:    result = ~(a | b);
            UAL_PASS_B: result = b;
            UAL_PASS_A: result = a;
            default:    result = a;
        endcase
    end

endmodule

// File: rtl/uc_datapath.sv
// rtl/uc_datapath.sv - accumulator CPU processing unit: R1/accu/carry, UAL, RAM and boot loader
module uc_datapath
    import uc_pkg::*;
#(
    parameter int ADDR_W = UC_ADDR_W,
    parameter int DATA_W = UC_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [UAL_SEL_W-1:0] sel_UAL,
    input  logic                 load_R1,
    input  logic                 load_accu,
    input  logic                 load_carry,
    input  logic                 clear_carry,
    input  logic                 enable_mem,
    input  logic                 w_mem,
    input  logic [ADDR_W-1:0]    adr,
    output logic [DATA_W-1:0]    data_out,
    output logic                 carry,
    output logic [DATA_W-1:0]    accu,
    input  logic                 boot,
    input  logic [DATA_W-1:0]    boot_data,
    input  logic                 boot_valid,
    output logic                 boot_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADR = '1;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] ual_result;
    logic              ual_carry;

    boot_state_t       state;
    boot_state_t       state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;
    logic              boot_we;

    logic              norm_we;
    logic              norm_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wadr;
    logic [DATA_W-1:0] mem_wdata;

    uc_ual #(
        .DATA_W(DATA_W)
    ) u_ual (
        .a        (accu),
        .b        (r1),
        .sel      (sel_UAL),
        .result   (ual_result),
        .carry_out(ual_carry)
    );

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        boot_we    = 1'b0;
        case (state)
            BOOT_IDLE: begin
                // A byte offered together with the boot request is dropped; loading starts in LOAD.
                if (boot) begin
                    state_next = BOOT_LOAD;
                    ptr_next   = '0;
                end
            end
            BOOT_LOAD: begin
                if (!boot) begin
                    state_next = BOOT_IDLE;
                end else if (boot_valid) begin
                    boot_we = 1'b1;
                    if (ptr == LAST_ADR) begin
                        state_next = BOOT_DONE;
                        ptr_next   = '0;
                    end else begin
                        ptr_next = ptr + 1'b1;
                    end
                end
            end
            BOOT_DONE: begin
                if (!boot) begin
                    state_next = BOOT_IDLE;
                end
            end
            default: state_next = BOOT_IDLE;
        endcase
    end

    // The control side owns the RAM port only while the loader is idle.
    assign norm_we   = (state == BOOT_IDLE) && enable_mem && w_mem;
    assign norm_re   = (state == BOOT_IDLE) && enable_mem && !w_mem;
    assign mem_we    = ce && !rst && (norm_we || boot_we);
    assign mem_wadr  = boot_we ? ptr : adr;
    assign mem_wdata = boot_we ? boot_data : accu;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wadr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1        <= '0;
            accu      <= '0;
            carry     <= 1'b0;
            data_out  <= '0;
            state     <= BOOT_IDLE;
            ptr       <= '0;
            boot_done <= 1'b0;
        end else if (ce) begin
            if (load_R1) begin
                r1 <= data_out;
            end
            if (load_accu) begin
                accu <= ual_result;
            end
            if (clear_carry) begin
                carry <= 1'b0;
            end else if (load_carry) begin
                carry <= ual_carry;
            end
            if (norm_re) begin
                data_out <= mem[adr];
            end
            state     <= state_next;
            ptr       <= ptr_next;
            boot_done <= (state_next == BOOT_DONE);
        end
    end

endmodule

// File: tb/tb_uc_datapath.sv
// tb/tb_uc_datapath.sv - directed and randomized checks of uc_datapath against a behavioural model
module tb_uc_datapath;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic [2:0]    sel_UAL;
    logic          load_R1;
    logic          load_accu;
    logic          load_carry;
    logic          clear_carry;
    logic          enable_mem;
    logic          w_mem;
    logic [AW-1:0] adr;
    logic [DW-1:0] data_out;
    logic          carry;
    logic [DW-1:0] accu;
    logic          boot;
    logic [DW-1:0] boot_data;
    logic          boot_valid;
    logic          boot_done;

    always #5 clk = ~clk;

    uc_datapath #(
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .sel_UAL    (sel_UAL),
        .load_R1    (load_R1),
        .load_accu  (load_accu),
        .load_carry (load_carry),
        .clear_carry(clear_carry),
        .enable_mem (enable_mem),
        .w_mem      (w_mem),
        .adr        (adr),
        .data_out   (data_out),
        .carry      (carry),
        .accu       (accu),
        .boot       (boot),
        .boot_data  (boot_data),
        .boot_valid (boot_valid),
        .boot_done  (boot_done)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: phase 0 = normal use, 1 = loading, 2 = RAM full.
    int m_accu, m_r1, m_carry, m_dout, m_done, m_phase, m_ptr;
    int m_mem [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ual(input int a, input int b, input int sel, output int r, output int c);
        c = 0;
        case (sel)
            0: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            1: begin r = (a - b + 256) % 256; c = (a >= b) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - (a | b);
            6: r = b;
            default: r = a;
        endcase
    endtask

    task automatic cycle(input string tag);
        int r, c;
        int n_accu, n_r1, n_carry, n_dout, n_phase, n_ptr, n_done;
        n_accu = m_accu; n_r1 = m_r1; n_carry = m_carry; n_dout = m_dout;
        n_phase = m_phase; n_ptr = m_ptr; n_done = m_done;
        if (rst) begin
            n_accu = 0; n_r1 = 0; n_carry = 0; n_dout = 0;
            n_phase = 0; n_ptr = 0; n_done = 0;
        end else if (ce) begin
            ual(m_accu, m_r1, int'(sel_UAL), r, c);
            if (load_R1)   n_r1 = m_dout;
            if (load_accu) n_accu = r;
            if (clear_carry)     n_carry = 0;
            else if (load_carry) n_carry = c;
            if (m_phase == 0) begin
                if (enable_mem && w_mem) m_mem[adr] = m_accu;
                else if (enable_mem)     n_dout = m_mem[adr];
                if (boot) begin n_phase = 1; n_ptr = 0; end
            end else if (m_phase == 1) begin
                if (!boot) n_phase = 0;
                else if (boot_valid) begin
                    m_mem[m_ptr] = int'(boot_data);
                    if (m_ptr == DEPTH - 1) begin n_phase = 2; n_ptr = 0; end
                    else n_ptr = m_ptr + 1;
                end
            end else if (!boot) begin
                n_phase = 0;
            end
            n_done = (n_phase == 2) ? 1 : 0;
        end
        @(posedge clk);
        #1;
        m_accu = n_accu; m_r1 = n_r1; m_carry = n_carry; m_dout = n_dout;
        m_phase = n_phase; m_ptr = n_ptr; m_done = n_done;
        if (!rst || compared > 0) begin
            check({tag, ".accu"},      32'(accu),      32'(m_accu));
            check({tag, ".carry"},     32'(carry),     32'(m_carry));
            check({tag, ".data_out"},  32'(data_out),  32'(m_dout));
            check({tag, ".boot_done"}, 32'(boot_done), 32'(m_done));
        end
    endtask

    task automatic quiet();
        rst = 1'b0; ce = 1'b1; sel_UAL = 3'b000;
        load_R1 = 1'b0; load_accu = 1'b0; load_carry = 1'b0; clear_carry = 1'b0;
        enable_mem = 1'b0; w_mem = 1'b0; adr = '0;
        boot_valid = 1'b0; boot_data = '0;
    endtask

    task automatic rd(input int a);
        quiet(); enable_mem = 1'b1; adr = AW'(a); cycle("read");
    endtask

    task automatic wr(input int a);
        quiet(); enable_mem = 1'b1; w_mem = 1'b1; adr = AW'(a); cycle("write");
    endtask

    task automatic ld_r1();
        quiet(); load_R1 = 1'b1; cycle("load_r1");
    endtask

    task automatic op(input int sel, input logic la, input logic lc, input logic cc);
        quiet(); sel_UAL = 3'(sel); load_accu = la; load_carry = lc; clear_carry = cc;
        cycle("ual_op");
    endtask

    logic [DW-1:0] prev_dout;

    initial begin
        m_accu = 0; m_r1 = 0; m_carry = 0; m_dout = 0; m_done = 0; m_phase = 0; m_ptr = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        quiet(); boot = 1'b0;

        // reset
        rst = 1'b1; cycle("reset"); cycle("reset");
        check("reset.accu", 32'(accu), 32'h0);
        check("reset.boot_done", 32'(boot_done), 32'h0);

        // full boot load 0x00..0x3F
        quiet(); boot = 1'b1; cycle("boot_start");
        for (int i = 0; i < DEPTH; i++) begin
            boot_valid = 1'b1; boot_data = DW'(i); cycle("boot_byte");
            if (i == DEPTH - 2) check("boot.done_early", 32'(boot_done), 32'h0);
        end
        check("boot.done_after_last", 32'(boot_done), 32'h1);
        quiet(); boot = 1'b0; cycle("boot_release");
        check("boot.done_falls", 32'(boot_done), 32'h0);
        rd(8'h2A);
        check("boot.read_2a", 32'(data_out), 32'h2A);

        // build 0xF0 in RAM, then ADD 0x20 + 0xF0
        rd(8'h0F); ld_r1(); op(6, 1'b1, 1'b0, 1'b0); op(5, 1'b1, 1'b0, 1'b0);
        wr(8'h3E);
        rd(8'h20); ld_r1(); op(6, 1'b1, 1'b0, 1'b0);
        rd(8'h3E); ld_r1();
        op(0, 1'b1, 1'b1, 1'b0);
        check("add.accu", 32'(accu), 32'h10);
        check("add.carry", 32'(carry), 32'h1);

        // SUB 0x05 - 0x07, then clear_carry beats load_carry
        rd(8'h05); ld_r1(); op(6, 1'b1, 1'b0, 1'b0);
        rd(8'h07); ld_r1();
        op(1, 1'b1, 1'b1, 1'b0);
        check("sub.accu", 32'(accu), 32'hFE);
        check("sub.carry", 32'(carry), 32'h0);
        op(6, 1'b1, 1'b0, 1'b0);
        op(0, 1'b0, 1'b1, 1'b0);
        op(1, 1'b0, 1'b1, 1'b1);
        check("clear_prio.carry", 32'(carry), 32'h0);

        // accu = 0x2D + 0x2D = 0x5A, write adr 3 then read it back
        rd(8'h2D); ld_r1(); op(6, 1'b1, 1'b0, 1'b0); op(0, 1'b1, 1'b0, 1'b0);
        prev_dout = data_out;
        wr(3);
        check("write.dout_holds", 32'(data_out), 32'(prev_dout));
        rd(3);
        check("write.readback", 32'(data_out), 32'h5A);

        // abort after 10 bytes
        quiet(); boot = 1'b1; cycle("abort_start");
        for (int i = 0; i < 10; i++) begin
            boot_valid = 1'b1; boot_data = DW'($urandom_range(0, 255)); cycle("abort_byte");
        end
        quiet(); boot = 1'b0; cycle("abort_drop");
        check("abort.done", 32'(boot_done), 32'h0);
        for (int i = 0; i < 12; i++) rd(i);

        // re-boot with ce low on alternate cycles
        quiet(); boot = 1'b1; cycle("stall_start");
        for (int k = 0; k < 400 && m_done == 0; k++) begin
            ce = (k % 2 == 0); boot_valid = 1'b1; boot_data = DW'($urandom_range(0, 255));
            cycle("stall_byte");
        end
        check("stall.done", 32'(boot_done), 32'h1);
        for (int k = 0; k < 3; k++) begin
            ce = 1'b1; boot_valid = 1'b1; boot_data = DW'($urandom_range(0, 255));
            enable_mem = 1'b1; w_mem = 1'b1; cycle("done_ignores");
        end
        quiet(); boot = 1'b0; cycle("stall_release");
        for (int i = 0; i < 6; i++) rd(i);
        rd(DEPTH - 1);

        // reset in the middle of a load
        quiet(); boot = 1'b1; cycle("rst_load_start");
        for (int i = 0; i < 3; i++) begin
            boot_valid = 1'b1; boot_data = DW'($urandom_range(0, 255)); cycle("rst_load_byte");
        end
        quiet(); rst = 1'b1; boot = 1'b0; cycle("rst_load_reset");
        rd(1); rd(5);

        // randomized normal-mode traffic
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 63) == 0);
            ce          = ($urandom_range(0, 7) != 0);
            sel_UAL     = 3'($urandom_range(0, 7));
            load_R1     = 1'($urandom_range(0, 1));
            load_accu   = 1'($urandom_range(0, 1));
            load_carry  = 1'($urandom_range(0, 1));
            clear_carry = ($urandom_range(0, 5) == 0);
            enable_mem  = 1'($urandom_range(0, 1));
            w_mem       = ($urandom_range(0, 3) == 0);
            adr         = AW'($urandom_range(0, DEPTH - 1));
            boot_valid  = 1'($urandom_range(0, 1));
            boot_data   = DW'($urandom_range(0, 255));
            boot        = 1'b0;
            cycle("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
